// File: rtl/bill_validator.sv
// Bill-path front end: synchronizes and debounces the optical sensor, measures
// occlusion width and turns each bill into exactly one Ten/Twenty/Reject outcome or a jam.
module bill_validator #(
    parameter int DEBOUNCE   = 4,
    parameter int TEN_MIN    = 20,
    parameter int TEN_MAX    = 39,
    parameter int TWENTY_MIN = 40,
    parameter int TWENTY_MAX = 79,
    parameter int JAM_CYCLES = 200,
    parameter int HOLDOFF    = 8,
    parameter int CNT_W      = 8
) (
    input  logic Clock,
    input  logic ClearN,
    input  logic BillSense,
    input  logic Accept,
    output logic Ten,
    output logic Twenty,
    output logic Reject,
    output logic Jam,
    output logic Busy
);

    localparam int DB_W = $clog2(DEBOUNCE + 1);
    localparam int HO_W = $clog2(HOLDOFF + 1);

    localparam logic [CNT_W-1:0] TEN_MIN_C    = CNT_W'(TEN_MIN);
    localparam logic [CNT_W-1:0] TEN_MAX_C    = CNT_W'(TEN_MAX);
    localparam logic [CNT_W-1:0] TWENTY_MIN_C = CNT_W'(TWENTY_MIN);
    localparam logic [CNT_W-1:0] TWENTY_MAX_C = CNT_W'(TWENTY_MAX);
    localparam logic [CNT_W-1:0] JAM_C        = CNT_W'(JAM_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX_C    = {CNT_W{1'b1}};
    localparam logic [DB_W-1:0]  DB_LAST_C    = DB_W'(DEBOUNCE - 1);
    localparam logic [HO_W-1:0]  HO_LAST_C    = HO_W'(HOLDOFF - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_MEASURE  = 3'd1,
        ST_CLASSIFY = 3'd2,
        ST_JAM      = 3'd3,
        ST_HOLDOFF  = 3'd4
    } state_t;

    function automatic logic in_range(input logic [CNT_W-1:0] w,
                                      input logic [CNT_W-1:0] lo,
                                      input logic [CNT_W-1:0] hi);
        return (w >= lo) && (w <= hi);
    endfunction

    logic             sync1_q, sync2_q;
    logic             filt_q, filt_d;
    logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [HO_W-1:0]  ho_cnt_q, ho_cnt_d;
    logic             acc_ok_q, acc_ok_d;
    logic             ten_q, ten_d;
    logic             twenty_q, twenty_d;
    logic             reject_q, reject_d;
    logic             jam_q, jam_d;
    logic             busy_q, busy_d;

    // Two-flop synchronizer for the asynchronous sensor.
    always_ff @(posedge Clock or negedge ClearN) begin
        if (!ClearN) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= BillSense;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: follow S only after it has disagreed for DEBOUNCE cycles in a row.
    always_comb begin
        filt_d   = filt_q;
        db_cnt_d = {DB_W{1'b0}};
        if (sync2_q != filt_q) begin
            if (db_cnt_q == DB_LAST_C) begin
                filt_d   = sync2_q;
                db_cnt_d = {DB_W{1'b0}};
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end else begin
            db_cnt_d = {DB_W{1'b0}};
        end
    end

    // Debounce state registers.
    always_ff @(posedge Clock or negedge ClearN) begin
        if (!ClearN) begin
            filt_q   <= 1'b0;
            db_cnt_q <= {DB_W{1'b0}};
        end else begin
            filt_q   <= filt_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    // Bill FSM: the entry cycle is counted as width 1, so W equals the filtered high width.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ho_cnt_d = ho_cnt_q;
        acc_ok_d = acc_ok_q;
        ten_d    = 1'b0;
        twenty_d = 1'b0;
        reject_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (filt_q) begin
                    acc_ok_d = Accept;
                    cnt_d    = CNT_W'(1);
                    state_d  = ST_MEASURE;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_MEASURE: begin
                if (cnt_q >= JAM_C) begin
                    state_d = ST_JAM;
                end else if (!filt_q) begin
                    state_d = ST_CLASSIFY;
                end else if (cnt_q != CNT_MAX_C) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_CLASSIFY: begin
                if (acc_ok_q && in_range(cnt_q, TEN_MIN_C, TEN_MAX_C)) begin
                    ten_d = 1'b1;
                end else if (acc_ok_q && in_range(cnt_q, TWENTY_MIN_C, TWENTY_MAX_C)) begin
                    twenty_d = 1'b1;
                end else begin
                    reject_d = 1'b1;
                end
                ho_cnt_d = {HO_W{1'b0}};
                state_d  = ST_HOLDOFF;
            end
            ST_JAM: begin
                if (!filt_q) begin
                    ho_cnt_d = {HO_W{1'b0}};
                    state_d  = ST_HOLDOFF;
                end else begin
                    state_d  = ST_JAM;
                end
            end
            ST_HOLDOFF: begin
                // A bill arriving before the holdoff expires is measured but always rejected.
                if (filt_q) begin
                    acc_ok_d = 1'b0;
                    cnt_d    = CNT_W'(1);
                    state_d  = ST_MEASURE;
                end else if (ho_cnt_q == HO_LAST_C) begin
                    state_d  = ST_IDLE;
                end else begin
                    ho_cnt_d = ho_cnt_q + HO_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        jam_d  = (state_d == ST_JAM);
        busy_d = (state_d != ST_IDLE);
    end

    // FSM state, counters and registered outputs.
    always_ff @(posedge Clock or negedge ClearN) begin
        if (!ClearN) begin
            state_q  <= ST_IDLE;
            cnt_q    <= {CNT_W{1'b0}};
            ho_cnt_q <= {HO_W{1'b0}};
            acc_ok_q <= 1'b0;
            ten_q    <= 1'b0;
            twenty_q <= 1'b0;
            reject_q <= 1'b0;
            jam_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ho_cnt_q <= ho_cnt_d;
            acc_ok_q <= acc_ok_d;
            ten_q    <= ten_d;
            twenty_q <= twenty_d;
            reject_q <= reject_d;
            jam_q    <= jam_d;
            busy_q   <= busy_d;
        end
    end

    assign Ten    = ten_q;
    assign Twenty = twenty_q;
    assign Reject = reject_q;
    assign Jam    = jam_q;
    assign Busy   = busy_q;

endmodule
